m68k_region_decoder: RTL and testbench
======================================

Name: m68k_region_decoder

Overview:
Parametrised, registered 68000 bus decoder and cycle controller that replaces fixed per-PCB chip-select logic.
- Region base, mask, direction and timing come from a runtime configuration table, loaded per PCB by the top level.
- Produces one-hot registered chip selects and drives DTACK_n/BERR_n with per-region wait states, an optional external-ready handshake, and an unmapped/timeout bus error.
- Sits between the fx68k core and the memory/IO blocks.

Parameters:
N_REGIONS, 16, number of decodable regions (1..32)
AW, 24, address width
WS_W, 4, wait-state count width
TIMEOUT, 255, cycles from cycle start to bus error
IDX_W, 4, width of region index output (>= clog2(N_REGIONS))

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
m68k_a  in  AW  byte address
m68k_as_n  in  1  address strobe
m68k_rw  in  1  1=read, 0=write
cfg_base  in  N_REGIONS*AW  region i base at [i*AW +: AW]
cfg_mask  in  N_REGIONS*AW  compare mask, 1=bit compared
cfg_en  in  N_REGIONS  region enable
cfg_dir  in  N_REGIONS*2  00 rw, 01 read-only, 10 write-only, 11 disabled
cfg_ws  in  N_REGIONS*WS_W  wait states before DTACK
cfg_ext  in  N_REGIONS  1 = also wait for ext_ready
ext_ready  in  1  external slave ready (SDRAM ROM path)
cs  out  N_REGIONS  registered one-hot chip select
cs_idx  out  IDX_W  index of active region
cs_valid  out  1  any cs asserted
dtack_n  out  1  data acknowledge
berr_n  out  1  bus error
unmapped  out  1  one-cycle pulse when a cycle hits no region

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; cs=0, cs_idx=0, cs_valid=0, dtack_n=1, berr_n=1, unmapped=0, counters=0. Reset mid-cycle aborts immediately; no DTACK is issued for that cycle.
- Region i matches when all of the following hold:
  - ((m68k_a ^ base_i) & mask_i) == 0
  - cfg_en[i] = 1
  - the direction is permitted: 01 requires rw=1, 10 requires rw=0, 11 never matches.
- On overlapping matches the lowest index wins.
- States: IDLE, WAIT, EXT, ACK, ERR.
- IDLE: when as_n is sampled low:
  - hit: register cs[idx], cs_idx, cs_valid=1; load ws counter; go to WAIT.
  - miss: unmapped pulses 1 cycle; go to ERR.
  - cs therefore rises 1 cycle after as_n is sampled low.
- WAIT: decrement the counter each cycle. When the counter is 0:
  - cfg_ext=0: go to ACK.
  - cfg_ext=1: go to EXT.
  - With ws=0 and no ext, DTACK follows cs by 1 cycle. ws=k gives k+1 cycles from cs to dtack_n low.
- EXT: stay until ext_ready is sampled high, then go to ACK.
- ACK: dtack_n=0, held until as_n is sampled high.
- ERR: berr_n=0, entered only at TIMEOUT (see below); held until as_n is sampled high.
- Timeout counter:
  - Cleared in IDLE; counts every cycle while not IDLE. Saturates; never wraps.
  - Reaching TIMEOUT in WAIT, EXT or an unmapped cycle forces ERR: berr_n=0, dtack_n=1.
  - An unmapped cycle errors at TIMEOUT cycles, not immediately, to mimic an open bus.
- as_n sampled high in any non-IDLE state:
  - Next cycle: cs=0, cs_valid=0, dtack_n=1, berr_n=1, state IDLE.
  - An early abort (before ACK) is legal and issues no DTACK.
- Back-to-back cycles: as_n must be seen high for at least 1 cycle. Decode of a new cycle starts on the first low sample after IDLE is re-entered.
- The address and cfg_* are sampled only at the IDLE->WAIT decision. cfg changes mid-cycle do not affect the current cycle.
- dtack_n and berr_n are never low simultaneously.

Decomposition:
- Package snk68_bus_pkg:
  - dir encodings DIR_RW, DIR_RO, DIR_WO, DIR_OFF
  - state enum
  - default TIMEOUT and WS_W constants
  - per-PCB region-table constants (pcb_A7007_A8007, pcb_A7008, pcb_A7008_SS) for the top level to drive cfg_*
- Sub-module region_match_prio: combinational N-way match plus lowest-index priority encoder. Outputs hit, idx, onehot.

Test Plan:
- A7008 table, read 0x040010 (RAM, region 2, ws=0) -> cs[2] high 1 cycle after as_n low; dtack_n low 1 cycle later; both clear 1 cycle after as_n high.
- Region ws=3, read -> dtack_n low exactly 4 cycles after cs; cs_idx stable throughout.
- ROM region cfg_ext=1, ext_ready raised 10 cycles after cs -> dtack_n low the cycle after ext_ready is sampled; never low earlier.
- Write to a read-only region (0x0c0000 coin input) -> no cs; unmapped pulse; berr_n low at cycle 255; dtack_n stays 1.
- Overlap: region 1 base 0x080000 mask 0xfffffe and region 5 covering 0x080000 -> cs[1] only.
- Abort and reset: as_n high during WAIT -> no dtack, IDLE next cycle. reset_n low during EXT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/snk68_bus_pkg.sv
// Shared 68000 bus types: region direction codes, cycle states,
// and the per-PCB region tables the system top drives onto cfg_*.
package snk68_bus_pkg;

    localparam logic [1:0] DIR_RW  = 2'b00;
    localparam logic [1:0] DIR_RO  = 2'b01;
    localparam logic [1:0] DIR_WO  = 2'b10;
    localparam logic [1:0] DIR_OFF = 2'b11;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_WS_W    = 4;

    localparam int PCB_N  = 16;
    localparam int PCB_AW = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXT,
        ST_ACK,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        BOARD_A7007_A8007,
        BOARD_A7008,
        BOARD_A7008_SS
    } board_t;

    typedef struct packed {
        logic [PCB_N*PCB_AW-1:0]   base;
        logic [PCB_N*PCB_AW-1:0]   mask;
        logic [PCB_N-1:0]          en;
        logic [PCB_N*2-1:0]        dir;
        logic [PCB_N*DEF_WS_W-1:0] ws;
        logic [PCB_N-1:0]          ext;
    } pcb_table_t;

    function automatic logic dir_ok(input logic [1:0] d, input logic rw);
        logic ok;
        unique case (d)
            DIR_RW:  ok = 1'b1;
            DIR_RO:  ok = rw;
            DIR_WO:  ok = !rw;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic pcb_table_t put_region(
        input pcb_table_t           t,
        input int                   i,
        input logic [PCB_AW-1:0]    b,
        input logic [PCB_AW-1:0]    m,
        input logic [1:0]           d,
        input logic [DEF_WS_W-1:0]  w,
        input logic                 x
    );
        pcb_table_t r;
        r = t;
        r.base[i*PCB_AW +: PCB_AW]     = b;
        r.mask[i*PCB_AW +: PCB_AW]     = m;
        r.en[i]                        = 1'b1;
        r.dir[i*2 +: 2]                = d;
        r.ws[i*DEF_WS_W +: DEF_WS_W]   = w;
        r.ext[i]                       = x;
        return r;
    endfunction

    // Region 1 (sound latch word) sits inside region 5 (IO block) on
    // purpose: the lower index takes priority for the latch address.
    function automatic pcb_table_t build_table(input board_t p);
        pcb_table_t t;
        logic [PCB_AW-1:0] rom_mask;
        logic [PCB_AW-1:0] spr_mask;
        t = '0;
        rom_mask = (p == BOARD_A7008_SS) ? 24'hf80000 : 24'hfc0000;
        spr_mask = (p == BOARD_A7007_A8007) ? 24'hffc000 : 24'hff8000;
        t = put_region(t, 0, 24'h000000, rom_mask,    DIR_RO, 4'd0, 1'b1);
        t = put_region(t, 1, 24'h080000, 24'hfffffe, DIR_RW, 4'd0, 1'b0);
        t = put_region(t, 2, 24'h040000, 24'hffc000, DIR_RW, 4'd0, 1'b0);
        t = put_region(t, 3, 24'h0c0000, 24'hfffffe, DIR_RO, 4'd1, 1'b0);
        t = put_region(t, 4, 24'h200000, spr_mask,    DIR_RW, 4'd1, 1'b0);
        t = put_region(t, 5, 24'h080000, 24'hfc0000, DIR_RW, 4'd2, 1'b0);
        t = put_region(t, 6, 24'h100000, 24'hfff000, DIR_RW, 4'd0, 1'b0);
        t = put_region(t, 7, 24'h400000, 24'hfff000, DIR_RW, 4'd3, 1'b0);
        return t;
    endfunction

    localparam pcb_table_t pcb_A7007_A8007 = build_table(BOARD_A7007_A8007);
    localparam pcb_table_t pcb_A7008       = build_table(BOARD_A7008);
    localparam pcb_table_t pcb_A7008_SS    = build_table(BOARD_A7008_SS);

endpackage

// File: rtl/region_match_prio.sv
// Combinational N-way region compare with lowest-index priority.
// Outputs the winning region as hit flag, binary index and one-hot.
module region_match_prio
    import snk68_bus_pkg::*;
#(
    parameter int N_REGIONS = 16,
    parameter int AW        = 24,
    parameter int IDX_W     = 4
) (
    input  logic [AW-1:0]           addr,
    input  logic                    rw,
    input  logic [N_REGIONS*AW-1:0] base,
    input  logic [N_REGIONS*AW-1:0] mask,
    input  logic [N_REGIONS-1:0]    en,
    input  logic [N_REGIONS*2-1:0]  dir,
    output logic                    hit,
    output logic [IDX_W-1:0]        idx,
    output logic [N_REGIONS-1:0]    onehot
);

    logic [N_REGIONS-1:0] match;

    // Per-region address, enable and direction test.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            match[i] = (((addr ^ base[i*AW +: AW]) & mask[i*AW +: AW]) == '0)
                     && en[i]
                     && dir_ok(dir[i*2 +: 2], rw);
        end
    end

    // Scan from the top so the lowest matching index is the last written.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m68k_region_decoder.sv
// Registered 68000 chip-select decoder and DTACK/BERR cycle controller
// with per-region wait states, external ready and open-bus timeout.
module m68k_region_decoder
    import snk68_bus_pkg::*;
#(
    parameter int N_REGIONS = 16,
    parameter int AW        = 24,
    parameter int WS_W      = DEF_WS_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int IDX_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [AW-1:0]             m68k_a,
    input  logic                      m68k_as_n,
    input  logic                      m68k_rw,
    input  logic [N_REGIONS*AW-1:0]   cfg_base,
    input  logic [N_REGIONS*AW-1:0]   cfg_mask,
    input  logic [N_REGIONS-1:0]      cfg_en,
    input  logic [N_REGIONS*2-1:0]    cfg_dir,
    input  logic [N_REGIONS*WS_W-1:0] cfg_ws,
    input  logic [N_REGIONS-1:0]      cfg_ext,
    input  logic                      ext_ready,
    output logic [N_REGIONS-1:0]      cs,
    output logic [IDX_W-1:0]          cs_idx,
    output logic                      cs_valid,
    output logic                      dtack_n,
    output logic                      berr_n,
    output logic                      unmapped
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMAX = '1;

    logic                 hit;
    logic [IDX_W-1:0]     idx;
    logic [N_REGIONS-1:0] onehot;

    state_t               state;
    logic [WS_W-1:0]      ws_cnt;
    logic                 ext_sel;
    logic [TW-1:0]        tcnt;
    logic [TW-1:0]        tcnt_nxt;
    logic                 tmo;
    logic [WS_W-1:0]      ws_sel;
    logic                 ext_cfg;

    region_match_prio #(
        .N_REGIONS (N_REGIONS),
        .AW        (AW),
        .IDX_W     (IDX_W)
    ) u_match (
        .addr   (m68k_a),
        .rw     (m68k_rw),
        .base   (cfg_base),
        .mask   (cfg_mask),
        .en     (cfg_en),
        .dir    (cfg_dir),
        .hit    (hit),
        .idx    (idx),
        .onehot (onehot)
    );

    // Winning region's timing, plus the saturating timeout step.
    always_comb begin
        ws_sel   = cfg_ws[int'(idx)*WS_W +: WS_W];
        ext_cfg  = cfg_ext[idx];
        tcnt_nxt = (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
        tmo      = (tcnt_nxt >= TMO);
    end

    // Bus cycle FSM; as_n high in any active state ends the cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cs       <= '0;
            cs_idx   <= '0;
            cs_valid <= 1'b0;
            dtack_n  <= 1'b1;
            berr_n   <= 1'b1;
            unmapped <= 1'b0;
            ws_cnt   <= '0;
            ext_sel  <= 1'b0;
            tcnt     <= '0;
        end else begin
            unmapped <= 1'b0;
            if (state != ST_IDLE && m68k_as_n) begin
                state    <= ST_IDLE;
                cs       <= '0;
                cs_idx   <= '0;
                cs_valid <= 1'b0;
                dtack_n  <= 1'b1;
                berr_n   <= 1'b1;
                ws_cnt   <= '0;
                tcnt     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        tcnt <= '0;
                        if (!m68k_as_n) begin
                            if (hit) begin
                                cs       <= onehot;
                                cs_idx   <= idx;
                                cs_valid <= 1'b1;
                                ws_cnt   <= ws_sel;
                                ext_sel  <= ext_cfg;
                                state    <= ST_WAIT;
                            end else begin
                                unmapped <= 1'b1;
                                state    <= ST_ERR;
                            end
                        end
                    end
                    ST_WAIT: begin
                        tcnt <= tcnt_nxt;
                        if (tmo) begin
                            state  <= ST_ERR;
                            berr_n <= 1'b0;
                        end else if (ws_cnt == '0) begin
                            if (ext_sel) begin
                                state <= ST_EXT;
                            end else begin
                                state   <= ST_ACK;
                                dtack_n <= 1'b0;
                            end
                        end else begin
                            ws_cnt <= ws_cnt - WS_W'(1);
                        end
                    end
                    ST_EXT: begin
                        tcnt <= tcnt_nxt;
                        if (tmo) begin
                            state  <= ST_ERR;
                            berr_n <= 1'b0;
                        end else if (ext_ready) begin
                            state   <= ST_ACK;
                            dtack_n <= 1'b0;
                        end
                    end
                    ST_ACK: begin
                        tcnt <= tcnt_nxt;
                    end
                    ST_ERR: begin
                        tcnt <= tcnt_nxt;
                        if (tmo) begin
                            berr_n <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Self-checking bench for m68k_region_decoder: directed bus cycles on
// an A7008-style table plus randomized tables against a cycle model.
module tb_m68k_region_decoder;

    localparam int N  = 16;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int IW = 4;

    typedef struct {
        logic [N-1:0]  cs;
        logic [IW-1:0] idx;
        logic          valid;
        int            unm;
        int            dlat;
        int            blat;
        bit            both_low;
        bit            idx_chg;
        bit            late;
        logic [N-1:0]  cs_after;
        logic          valid_after;
        logic          dtack_after;
        logic          berr_after;
    } obs_t;

    logic            clk;
    logic            reset_n;
    logic [AW-1:0]   m68k_a;
    logic            m68k_as_n;
    logic            m68k_rw;
    logic [N*AW-1:0] cfg_base;
    logic [N*AW-1:0] cfg_mask;
    logic [N-1:0]    cfg_en;
    logic [N*2-1:0]  cfg_dir;
    logic [N*WW-1:0] cfg_ws;
    logic [N-1:0]    cfg_ext;
    logic            ext_ready;
    logic [N-1:0]    cs;
    logic [IW-1:0]   cs_idx;
    logic            cs_valid;
    logic            dtack_n;
    logic            berr_n;
    logic            unmapped;

    logic [AW-1:0] r_base [N];
    logic [AW-1:0] r_mask [N];
    logic          r_en   [N];
    logic [1:0]    r_dir  [N];
    logic [WW-1:0] r_ws   [N];
    logic          r_ext  [N];

    int vectors;
    int miscompares;

    m68k_region_decoder #(
        .N_REGIONS (N),
        .AW        (AW),
        .WS_W      (WW),
        .TIMEOUT   (255),
        .IDX_W     (IW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m68k_a    (m68k_a),
        .m68k_as_n (m68k_as_n),
        .m68k_rw   (m68k_rw),
        .cfg_base  (cfg_base),
        .cfg_mask  (cfg_mask),
        .cfg_en    (cfg_en),
        .cfg_dir   (cfg_dir),
        .cfg_ws    (cfg_ws),
        .cfg_ext   (cfg_ext),
        .ext_ready (ext_ready),
        .cs        (cs),
        .cs_idx    (cs_idx),
        .cs_valid  (cs_valid),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .unmapped  (unmapped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cfg_base[i*AW +: AW] = r_base[i];
            cfg_mask[i*AW +: AW] = r_mask[i];
            cfg_en[i]            = r_en[i];
            cfg_dir[i*2 +: 2]    = r_dir[i];
            cfg_ws[i*WW +: WW]   = r_ws[i];
            cfg_ext[i]           = r_ext[i];
        end
    end

    // Reference model: first enabled region whose compared bits match
    // and whose direction allows this access.
    function automatic int model_idx(input logic [AW-1:0] a, input logic rw);
        for (int i = 0; i < N; i++) begin
            bit dok;
            dok = (r_dir[i] == 2'd0) || (r_dir[i] == 2'd1 && rw)
               || (r_dir[i] == 2'd2 && !rw);
            if (r_en[i] && dok && ((a ^ r_base[i]) & r_mask[i]) == '0)
                return i;
        end
        return -1;
    endfunction

    // Cycles from cs to dtack low; -1 if no dtack is expected.
    function automatic int model_dlat(input int i, input int d);
        int w;
        int l;
        if (i < 0) return -1;
        w = int'(r_ws[i]);
        if (!r_ext[i]) return w + 1;
        if (d < 0) return -1;
        l = (w + 2 > d + 1) ? w + 2 : d + 1;
        return (l >= 255) ? -1 : l;
    endfunction

    function automatic int model_blat(input int i, input int d);
        if (i < 0) return 255;
        if (r_ext[i] && d < 0) return 255;
        return -1;
    endfunction

    task automatic load_a7008();
        logic [AW-1:0] b [8];
        logic [AW-1:0] m [8];
        logic [1:0]    dr[8];
        logic [WW-1:0] w [8];
        b  = '{24'h000000, 24'h080000, 24'h040000, 24'h0c0000,
               24'h200000, 24'h080000, 24'h100000, 24'h400000};
        m  = '{24'hfc0000, 24'hfffffe, 24'hffc000, 24'hfffffe,
               24'hff8000, 24'hfc0000, 24'hfff000, 24'hfff000};
        dr = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        w  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd3};
        for (int i = 0; i < N; i++) begin
            r_base[i] = (i < 8) ? b[i] : 24'h0;
            r_mask[i] = (i < 8) ? m[i] : 24'h0;
            r_en[i]   = (i < 8);
            r_dir[i]  = (i < 8) ? dr[i] : 2'd3;
            r_ws[i]   = (i < 8) ? w[i] : 4'd0;
            r_ext[i]  = (i == 0);
        end
    endtask

    // Runs one bus cycle and records what the DUT did; d is the ext_ready
    // delay after cs (-1 never), abort_at the sample at which as_n rises.
    task automatic bus_cycle(input logic [AW-1:0] addr, input logic rw,
                             input int d, input int abort_at,
                             input bit mid, output obs_t o);
        int n;
        int rel;
        logic [WW-1:0] sv_ws [N];
        logic          sv_en [N];
        logic          sv_ext[N];
        o.cs = 'x; o.idx = 'x; o.valid = 'x;
        o.unm = 0; o.dlat = -1; o.blat = -1;
        o.both_low = 0; o.idx_chg = 0; o.late = 0;
        o.cs_after = 'x; o.valid_after = 'x;
        o.dtack_after = 'x; o.berr_after = 'x;
        sv_ws = r_ws; sv_en = r_en; sv_ext = r_ext;
        m68k_a = addr; m68k_rw = rw; m68k_as_n = 1'b0; ext_ready = 1'b0;
        rel = -1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (unmapped === 1'b1) o.unm++;
            if (dtack_n === 1'b0 && berr_n === 1'b0) o.both_low = 1;
            if (n == 1) begin
                o.cs = cs; o.idx = cs_idx; o.valid = cs_valid;
                if (mid) begin
                    for (int i = 0; i < N; i++) begin
                        r_ws[i] = 4'd0; r_en[i] = 1'b0; r_ext[i] = 1'b0;
                    end
                end
            end else if (rel < 0 && cs_idx !== o.idx) begin
                o.idx_chg = 1;
            end
            if (rel >= 0 && n == rel + 1) begin
                o.cs_after = cs; o.valid_after = cs_valid;
                o.dtack_after = dtack_n; o.berr_after = berr_n;
                break;
            end
            if (rel < 0) begin
                if (o.dlat < 0 && dtack_n === 1'b0) o.dlat = n - 1;
                if (o.blat < 0 && berr_n === 1'b0) o.blat = n - 1;
                if (d >= 0 && n - 1 == d) ext_ready = 1'b1;
                if (o.dlat >= 0 || o.blat >= 0 || n == abort_at) begin
                    m68k_as_n = 1'b1;
                    rel = n;
                end
            end
        end
        m68k_as_n = 1'b1;
        ext_ready = 1'b0;
        r_ws = sv_ws; r_en = sv_en; r_ext = sv_ext;
        if (abort_at > 0) begin
            repeat (6) begin
                @(negedge clk);
                if (dtack_n !== 1'b1 || berr_n !== 1'b1 || cs !== '0)
                    o.late = 1;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; m68k_as_n = 1'b1; m68k_rw = 1'b1;
        m68k_a = '0; ext_ready = 1'b0;
        load_a7008();
        repeat (3) @(negedge clk);
        vectors++;
        if ({cs, cs_idx, cs_valid, dtack_n, berr_n, unmapped}
            !== {16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got cs=%h idx=%h v=%b dt=%b be=%b un=%b want 0/0/0/1/1/0",
                     cs, cs_idx, cs_valid, dtack_n, berr_n, unmapped);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        obs_t o;
        load_a7008();
        bus_cycle(24'h040010, 1'b1, -1, 0, 0, o);
        vectors++;
        if (o.cs !== 16'h0004 || o.idx !== 4'd2 || o.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ram_cs got cs=%h idx=%h v=%b want 0004/2/1", o.cs, o.idx, o.valid);
        end
        vectors++;
        if (o.dlat !== 1) begin
            miscompares++;
            $display("FAIL ram_dtack_lat got %0d want 1", o.dlat);
        end
        vectors++;
        if ({o.cs_after, o.valid_after, o.dtack_after, o.berr_after}
            !== {16'h0, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL ram_release got cs=%h v=%b dt=%b be=%b want 0/0/1/1",
                     o.cs_after, o.valid_after, o.dtack_after, o.berr_after);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        load_a7008();
        bus_cycle(24'h400010, 1'b1, -1, 0, 0, o);
        vectors++;
        if (o.dlat !== 4 || o.cs !== 16'h0080) begin
            miscompares++;
            $display("FAIL ws3_lat got lat=%0d cs=%h want 4/0080", o.dlat, o.cs);
        end
        vectors++;
        if (o.idx_chg !== 1'b0 || o.idx !== 4'd7) begin
            miscompares++;
            $display("FAIL ws3_idx_stable got idx=%h chg=%b want 7/0", o.idx, o.idx_chg);
        end
    endtask

    task automatic test_ext_ready();
        obs_t o;
        load_a7008();
        bus_cycle(24'h000100, 1'b1, 10, 0, 0, o);
        vectors++;
        if (o.dlat !== 11 || o.cs !== 16'h0001) begin
            miscompares++;
            $display("FAIL ext_lat got lat=%0d cs=%h want 11/0001", o.dlat, o.cs);
        end
    endtask

    task automatic test_ro_write();
        obs_t o;
        load_a7008();
        bus_cycle(24'h0c0000, 1'b0, -1, 0, 0, o);
        vectors++;
        if (o.cs !== 16'h0 || o.valid !== 1'b0 || o.unm !== 1) begin
            miscompares++;
            $display("FAIL ro_write_decode got cs=%h v=%b unm=%0d want 0/0/1",
                     o.cs, o.valid, o.unm);
        end
        vectors++;
        if (o.blat !== 255 || o.dlat !== -1) begin
            miscompares++;
            $display("FAIL ro_write_berr got blat=%0d dlat=%0d want 255/-1", o.blat, o.dlat);
        end
        vectors++;
        if (o.berr_after !== 1'b1 || o.dtack_after !== 1'b1) begin
            miscompares++;
            $display("FAIL ro_write_release got be=%b dt=%b want 1/1", o.berr_after, o.dtack_after);
        end
    endtask

    task automatic test_overlap();
        obs_t o;
        logic [AW-1:0] a [3];
        logic [N-1:0]  want [3];
        a    = '{24'h080000, 24'h080001, 24'h080002};
        want = '{16'h0002, 16'h0002, 16'h0020};
        load_a7008();
        for (int k = 0; k < 3; k++) begin
            bus_cycle(a[k], 1'b1, -1, 0, 0, o);
            vectors++;
            if (o.cs !== want[k]) begin
                miscompares++;
                $display("FAIL overlap_%0d got cs=%h want %h", k, o.cs, want[k]);
            end
        end
    endtask

    task automatic test_abort();
        obs_t o;
        load_a7008();
        bus_cycle(24'h400000, 1'b0, -1, 2, 0, o);
        vectors++;
        if (o.dlat !== -1 || o.late !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_dtack got dlat=%0d late=%b want -1/0", o.dlat, o.late);
        end
        vectors++;
        if (o.cs_after !== 16'h0 || o.valid_after !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle got cs=%h v=%b want 0/0", o.cs_after, o.valid_after);
        end
    endtask

    task automatic test_cfg_sample();
        obs_t o;
        load_a7008();
        bus_cycle(24'h400200, 1'b1, -1, 0, 1, o);
        vectors++;
        if (o.dlat !== 4 || o.cs !== 16'h0080) begin
            miscompares++;
            $display("FAIL cfg_midcycle got lat=%0d cs=%h want 4/0080", o.dlat, o.cs);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        load_a7008();
        bus_cycle(24'h040020, 1'b0, -1, 0, 0, o1);
        bus_cycle(24'h100004, 1'b1, -1, 0, 0, o2);
        vectors++;
        if (o1.cs !== 16'h0004 || o1.dlat !== 1 || o1.cs_after !== 16'h0) begin
            miscompares++;
            $display("FAIL b2b_first got cs=%h lat=%0d after=%h want 0004/1/0",
                     o1.cs, o1.dlat, o1.cs_after);
        end
        vectors++;
        if (o2.cs !== 16'h0040 || o2.idx !== 4'd6 || o2.dlat !== 1) begin
            miscompares++;
            $display("FAIL b2b_second got cs=%h idx=%h lat=%0d want 0040/6/1",
                     o2.cs, o2.idx, o2.dlat);
        end
    endtask

    task automatic test_reset_ext();
        load_a7008();
        m68k_a = 24'h000200; m68k_rw = 1'b1; m68k_as_n = 1'b0; ext_ready = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (cs !== 16'h0001 || dtack_n !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_ext_pre got cs=%h dt=%b want 0001/1", cs, dtack_n);
        end
        reset_n = 1'b0;
        m68k_as_n = 1'b1;
        ext_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cs, cs_idx, cs_valid, dtack_n, berr_n, unmapped}
            !== {16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_ext_state got cs=%h idx=%h v=%b dt=%b be=%b un=%b",
                     cs, cs_idx, cs_valid, dtack_n, berr_n, unmapped);
        end
        reset_n = 1'b1;
        ext_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (dtack_n !== 1'b1 || cs !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_ext_after got cs=%h dt=%b want 0/1", cs, dtack_n);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] m;
            logic          rw;
            int r;
            int d;
            int ei;
            int edl;
            int ebl;
            for (int i = 0; i < N; i++) begin
                m = 24'hffffff;
                m = m << $urandom_range(0, 20);
                r_base[i] = 24'($urandom);
                r_mask[i] = m;
                r_en[i]   = ($urandom % 4) != 0;
                r_dir[i]  = 2'($urandom);
                r_ws[i]   = 4'($urandom);
                r_ext[i]  = ($urandom % 3) == 0;
            end
            r = $urandom_range(0, N - 1);
            if ($urandom % 5 != 0)
                a = r_base[r] ^ (24'($urandom) & ~r_mask[r]);
            else
                a = 24'($urandom);
            rw = 1'($urandom);
            d = ($urandom % 10 == 0) ? -1 : $urandom_range(0, 20);
            ei  = model_idx(a, rw);
            edl = model_dlat(ei, d);
            ebl = model_blat(ei, d);
            bus_cycle(a, rw, d, 0, 0, o);
            vectors++;
            if (ei >= 0) begin
                if (o.cs !== (N'(1) << ei) || o.idx !== IW'(ei)
                    || o.valid !== 1'b1 || o.unm !== 0) begin
                    miscompares++;
                    $display("FAIL rnd_hit_%0d a=%h got cs=%h idx=%h v=%b unm=%0d want region %0d",
                             t, a, o.cs, o.idx, o.valid, o.unm, ei);
                end
            end else begin
                if (o.cs !== '0 || o.valid !== 1'b0 || o.unm !== 1) begin
                    miscompares++;
                    $display("FAIL rnd_miss_%0d a=%h got cs=%h v=%b unm=%0d want 0/0/1",
                             t, a, o.cs, o.valid, o.unm);
                end
            end
            vectors++;
            if (o.dlat !== edl || o.blat !== ebl || o.both_low || o.idx_chg) begin
                miscompares++;
                $display("FAIL rnd_timing_%0d a=%h got dlat=%0d blat=%0d both=%b chg=%b want %0d/%0d/0/0",
                         t, a, o.dlat, o.blat, o.both_low, o.idx_chg, edl, ebl);
            end
            vectors++;
            if ({o.cs_after, o.valid_after, o.dtack_after, o.berr_after}
                !== {16'h0, 1'b0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL rnd_release_%0d got cs=%h v=%b dt=%b be=%b want 0/0/1/1",
                         t, o.cs_after, o.valid_after, o.dtack_after, o.berr_after);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_ram_read();
        test_wait_states();
        test_ext_ready();
        test_ro_write();
        test_overlap();
        test_abort();
        test_cfg_sample();
        test_back_to_back();
        test_reset_ext();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
